// File: rtl/me_pkg.sv
// Shared types and helpers for the motion-estimation frame scheduler.
// Holds the FSM state encoding, core result widths and saturating add.
package me_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WRITE,
        S_ACKLOW,
        S_DONE
    } state_t;

    localparam int ME_SAD_W  = 16;
    localparam int ME_MVEC_W = 10;

    // Clamp a + b to 2^w-1; operands are assumed to fit in w bits.
    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned w
    );
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (65'd1 << w) - 65'd1;
        return (sum > lim) ? lim[63:0] : sum[63:0];
    endfunction

endpackage

// File: rtl/me_mb_counter.sv
// Raster-order macroblock counter with a running linear address.
// The address tracks mb_y*MB_COLS + mb_x without a multiplier.
module me_mb_counter
    import me_pkg::*;
#(
    parameter int MB_COLS = 4,
    parameter int MB_ROWS = 3,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    output logic [7:0]        mb_x,
    output logic [7:0]        mb_y,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [7:0] X_MAX = 8'(MB_COLS - 1);
    localparam logic [7:0] Y_MAX = 8'(MB_ROWS - 1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            mb_x <= '0;
            mb_y <= '0;
            addr <= '0;
        end else if (adv) begin
            addr <= addr + ADDR_W'(1);
            if (mb_x == X_MAX) begin
                mb_x <= '0;
                mb_y <= mb_y + 8'd1;
            end else begin
                mb_x <= mb_x + 8'd1;
            end
        end
    end

    assign last = (mb_x == X_MAX) && (mb_y == Y_MAX);

endmodule

// File: rtl/me_frame_sched.sv
// Frame scheduler: walks macroblocks, drives loader and ME core,
// writes per-MB results and accumulates frame SAD statistics.
module me_frame_sched
    import me_pkg::*;
#(
    parameter int MB_COLS = 4,
    parameter int MB_ROWS = 3,
    parameter int SAD_W   = ME_SAD_W,
    parameter int MVEC_W  = ME_MVEC_W,
    parameter int ADDR_W  = 8,
    parameter int TOT_W   = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [SAD_W-1:0]  sad_thr,
    output logic              busy,
    output logic              done,
    output logic [7:0]        mb_x,
    output logic [7:0]        mb_y,
    output logic              load_req,
    input  logic              load_ack,
    output logic              me_req,
    input  logic              me_ack,
    input  logic [SAD_W-1:0]  me_min_sad,
    input  logic [MVEC_W-1:0] me_min_mvec,
    output logic              res_we,
    output logic [ADDR_W-1:0] res_addr,
    output logic [SAD_W-1:0]  res_sad,
    output logic [MVEC_W-1:0] res_mvec,
    output logic [TOT_W-1:0]  sad_total,
    output logic [ADDR_W:0]   over_cnt
);

    state_t             state;
    logic [SAD_W-1:0]   thr;
    logic               we_q;
    logic               clr;
    logic               adv;
    logic               last;

    assign clr = (state == S_IDLE) && start && !abort;
    assign adv = (state == S_ACKLOW) && !abort && !me_ack && !last;

    // An abort landing on the WRITE cycle must not reach the buffer.
    assign res_we = we_q && !abort;

    me_mb_counter #(
        .MB_COLS (MB_COLS),
        .MB_ROWS (MB_ROWS),
        .ADDR_W  (ADDR_W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .adv  (adv),
        .mb_x (mb_x),
        .mb_y (mb_y),
        .addr (res_addr),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            thr       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            load_req  <= 1'b0;
            me_req    <= 1'b0;
            we_q      <= 1'b0;
            res_sad   <= '0;
            res_mvec  <= '0;
            sad_total <= '0;
            over_cnt  <= '0;
        end else if (abort && state != S_IDLE) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            load_req <= 1'b0;
            me_req   <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        sad_total <= '0;
                        over_cnt  <= '0;
                        thr       <= sad_thr;
                        busy      <= 1'b1;
                        load_req  <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (load_ack) begin
                        load_req <= 1'b0;
                        me_req   <= 1'b1;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (me_ack) begin
                        res_sad  <= me_min_sad;
                        res_mvec <= me_min_mvec;
                        me_req   <= 1'b0;
                        we_q     <= 1'b1;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    we_q      <= 1'b0;
                    sad_total <= TOT_W'(sat_add(64'(sad_total),
                                                64'(res_sad), TOT_W));
                    if (res_sad > thr)
                        over_cnt <= over_cnt + (ADDR_W+1)'(1);
                    state     <= S_ACKLOW;
                end
                S_ACKLOW: begin
                    if (!me_ack) begin
                        if (last) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            load_req <= 1'b1;
                            state    <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_me_frame_sched.sv
// Directed bench for me_frame_sched on a 2x2 frame with loader/core
// models; a second instance with an 8-bit accumulator covers saturation.
module tb_me_frame_sched;

    localparam int SW = 16;
    localparam int MW = 10;
    localparam int AW = 8;
    localparam int TW = 24;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [SW-1:0] sad_thr;
    logic          load_ack, me_ack;
    logic [SW-1:0] me_min_sad;
    logic [MW-1:0] me_min_mvec;

    logic          busy, done, load_req, me_req, res_we;
    logic [7:0]    mb_x, mb_y;
    logic [AW-1:0] res_addr;
    logic [SW-1:0] res_sad;
    logic [MW-1:0] res_mvec;
    logic [TW-1:0] sad_total;
    logic [AW:0]   over_cnt;

    logic          s_busy, s_done, s_load_req, s_me_req, s_res_we;
    logic [7:0]    s_mb_x, s_mb_y;
    logic [AW-1:0] s_res_addr;
    logic [SW-1:0] s_res_sad;
    logic [MW-1:0] s_res_mvec;
    logic [7:0]    s_sad_total;
    logic [AW:0]   s_over_cnt;

    always #5 clk = ~clk;

    me_frame_sched #(
        .MB_COLS(2), .MB_ROWS(2), .SAD_W(SW), .MVEC_W(MW),
        .ADDR_W(AW), .TOT_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .sad_thr(sad_thr), .busy(busy), .done(done),
        .mb_x(mb_x), .mb_y(mb_y),
        .load_req(load_req), .load_ack(load_ack),
        .me_req(me_req), .me_ack(me_ack),
        .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec),
        .res_we(res_we), .res_addr(res_addr),
        .res_sad(res_sad), .res_mvec(res_mvec),
        .sad_total(sad_total), .over_cnt(over_cnt)
    );

    me_frame_sched #(
        .MB_COLS(2), .MB_ROWS(2), .SAD_W(SW), .MVEC_W(MW),
        .ADDR_W(AW), .TOT_W(8)
    ) dut_sat (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .sad_thr(sad_thr), .busy(s_busy), .done(s_done),
        .mb_x(s_mb_x), .mb_y(s_mb_y),
        .load_req(s_load_req), .load_ack(load_ack),
        .me_req(s_me_req), .me_ack(me_ack),
        .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec),
        .res_we(s_res_we), .res_addr(s_res_addr),
        .res_sad(s_res_sad), .res_mvec(s_res_mvec),
        .sad_total(s_sad_total), .over_cnt(s_over_cnt)
    );

    int errs = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Loader: acks with a one-cycle pulse on the 3rd cycle of load_req.
    bit ld_en = 1'b1;
    bit inj_ack = 1'b0;
    int ld_cnt = 0;
    initial begin
        load_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (load_ack) begin
                load_ack = 1'b0;
            end else if (inj_ack) begin
                load_ack = 1'b1;
                inj_ack = 1'b0;
            end else if (load_req && ld_en) begin
                ld_cnt++;
                if (ld_cnt == 3) begin
                    load_ack = 1'b1;
                    ld_cnt = 0;
                end
            end else begin
                ld_cnt = 0;
            end
        end
    end

    // Core: acks 2 cycles into me_req, holding ack for ack_len cycles.
    int sads[4];
    int idx = 0;
    int ack_len = 1;
    int cc = 0;
    int hold = 0;
    initial begin
        me_ack = 1'b0;
        me_min_sad = '0;
        me_min_mvec = '0;
        forever begin
            @(negedge clk);
            if (hold > 0) begin
                hold--;
                if (hold == 0) me_ack = 1'b0;
            end else if (me_req) begin
                cc++;
                if (cc == 2) begin
                    me_ack = 1'b1;
                    me_min_sad = SW'(sads[idx % 4]);
                    me_min_mvec = MW'(idx + 5);
                    idx++;
                    hold = ack_len;
                    cc = 0;
                end
            end else begin
                cc = 0;
            end
        end
    end

    int wr_addr[16];
    int wr_sad[16];
    int wr_mv[16];
    int nw = 0;
    int ndone = 0;
    int viol = 0;
    logic prev_lr = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (res_we) begin
                if (nw < 16) begin
                    wr_addr[nw] = int'(res_addr);
                    wr_sad[nw] = int'(res_sad);
                    wr_mv[nw] = int'(res_mvec);
                end
                nw++;
            end
            if (done) ndone++;
            if (load_req && !prev_lr && me_ack) viol++;
            prev_lr = load_req;
        end
    end

    task automatic run(input logic [SW-1:0] thr);
        sad_thr = thr;
        idx = 0;
        nw = 0;
        ndone = 0;
        viol = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        check(tag, 64'(k < 400), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_mb1_run();
        int k;
        for (k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if (me_req && mb_x == 8'd1) break;
        end
        check("mb1_run_seen", 64'(k < 400), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        sad_thr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_load_req", 64'(load_req), 0);
        check("rst_me_req", 64'(me_req), 0);
        check("rst_res_we", 64'(res_we), 0);
        check("rst_total", 64'(sad_total), 0);
        check("rst_over", 64'(over_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic frame with one-cycle core ack.
        sads = '{50, 150, 100, 200};
        ack_len = 1;
        run(16'd100);
        wait_done("t1_done_seen");
        check("t1_nw", 64'(nw), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_addr%0d", i), 64'(wr_addr[i]), 64'(i));
            check($sformatf("t1_sad%0d", i), 64'(wr_sad[i]),
                  64'(sads[i]));
        end
        check("t1_mvec2", 64'(wr_mv[2]), 7);
        check("t1_total", 64'(sad_total), 500);
        check("t1_over", 64'(over_cnt), 2);
        check("t1_ndone", 64'(ndone), 1);
        check("t1_busy_end", 64'(busy), 0);
        check("t1_sat_total", 64'(s_sad_total), 255);

        // Core holding ack as a level for 5 cycles.
        sads = '{10, 20, 30, 40};
        ack_len = 5;
        run(16'd15);
        wait_done("t2_done_seen");
        check("t2_nw", 64'(nw), 4);
        check("t2_addr3", 64'(wr_addr[3]), 3);
        check("t2_total", 64'(sad_total), 100);
        check("t2_over", 64'(over_cnt), 3);
        check("t2_lreq_vs_ack", 64'(viol), 0);
        check("t2_ndone", 64'(ndone), 1);
        check("t2_sat_total", 64'(s_sad_total), 100);

        // Saturation on the 8-bit accumulator.
        sads = '{200, 200, 200, 200};
        ack_len = 1;
        run(16'd250);
        wait_done("t3_done_seen");
        check("t3_total", 64'(sad_total), 800);
        check("t3_sat_total", 64'(s_sad_total), 255);
        check("t3_over", 64'(over_cnt), 0);

        // Abort while MB 1 is in RUN.
        sads = '{7, 8, 9, 10};
        run(16'd0);
        wait_mb1_run();
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        check("t4_me_req", 64'(me_req), 0);
        check("t4_busy", 64'(busy), 0);
        @(negedge clk);
        abort = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t4_nw", 64'(nw), 1);
        check("t4_ndone", 64'(ndone), 0);
        check("t4_mb_x_hold", 64'(mb_x), 1);
        check("t4_total_held", 64'(sad_total), 7);
        check("t4_over_held", 64'(over_cnt), 1);
        sads = '{1, 2, 3, 4};
        run(16'd0);
        @(posedge clk);
        #1;
        check("t4r_busy", 64'(busy), 1);
        check("t4r_addr0", 64'(res_addr), 0);
        check("t4r_total_clr", 64'(sad_total), 0);
        check("t4r_over_clr", 64'(over_cnt), 0);
        wait_done("t4r_done_seen");
        check("t4r_nw", 64'(nw), 4);
        check("t4r_first_addr", 64'(wr_addr[0]), 0);
        check("t4r_total", 64'(sad_total), 10);
        check("t4r_over", 64'(over_cnt), 4);

        // Start pulsed mid-frame is ignored.
        sads = '{5, 6, 7, 8};
        run(16'd6);
        wait_mb1_run();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5_done_seen");
        check("t5_nw", 64'(nw), 4);
        check("t5_addr3", 64'(wr_addr[3]), 3);
        check("t5_ndone", 64'(ndone), 1);
        check("t5_total", 64'(sad_total), 26);
        check("t5_over", 64'(over_cnt), 2);

        // Start together with abort in IDLE is ignored.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;
        check("t5_sa_busy", 64'(busy), 0);
        check("t5_sa_lreq", 64'(load_req), 0);

        // Reset mid-LOAD, then a stray load_ack.
        ld_en = 1'b0;
        run(16'd0);
        @(posedge clk);
        #1;
        check("t6_in_load", 64'(load_req), 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_busy", 64'(busy), 0);
        check("t6_lreq", 64'(load_req), 0);
        check("t6_total", 64'(sad_total), 0);
        check("t6_res_sad", 64'(res_sad), 0);
        @(negedge clk);
        rst = 1'b0;
        inj_ack = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t6_late_busy", 64'(busy), 0);
        check("t6_late_me_req", 64'(me_req), 0);
        check("t6_late_lreq", 64'(load_req), 0);
        ld_en = 1'b1;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
